// File: rtl/regfile_wr_sched_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-port scheduler.
//   RF_DATA_W / RF_ADDR_W / RF_NREG : default geometry of the register file
//   state_t                         : scheduler FSM states (CLEAR, RUN)
//   wr_req_t                        : one writeback request (addr, data)
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREG   = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   i_valid[1:0] : request lines (already masked by the caller)
//   i_prio       : requester that wins a tie (0 or 1)
//   i_transfer   : a granted request is being taken this cycle
//   o_grant[1:0] : one-hot (or zero) grant
//   o_prio_nxt   : priority for the next cycle
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    input  logic       i_transfer,
    output logic [1:0] o_grant,
    output logic       o_prio_nxt
);

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_prio ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // After a transfer the priority moves to whoever was not served:
    // serving requester 0 hands priority to 1 and vice versa.
    assign o_prio_nxt = i_transfer ? o_grant[0] : i_prio;

endmodule

// File: rtl/regfile_wr_sched.sv
// ---------------------------------------------------------------------------
// regfile_wr_sched
// Owns the single write port (we3/wa3/wd3) of a 2R/1W register file.
//   - Round-robin sharing of the port between two writeback requesters.
//   - Zero-clear of registers 1..NREG-1 after reset or on clear_req.
//   - Read bypass so readers see the write currently on rf_* .
// Ports:
//   clock, reset              : clock, async active-high reset
//   clear_req / clear_busy    : start a clear (RUN only) / clear in progress
//   reqN_valid/ready/addr/data: writeback requester N (N = 0, 1)
//   rf_we3/rf_wa3/rf_wd3      : registered write port to the register file
//   ra1, ra2                  : read addresses
//   rf_rd1, rf_rd2            : raw register-file read data
//   rd1, rd2                  : bypassed read data
// The request struct uses the package geometry, so DATA_W/ADDR_W must match
// the package defaults, and NREG must equal 2**ADDR_W.
// ---------------------------------------------------------------------------
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREG   = RF_NREG
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_we3,
    output logic [ADDR_W-1:0] rf_wa3,
    output logic [DATA_W-1:0] rf_wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(NREG - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_prio;
    logic              r_we;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_clr_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_wa_nxt;
    logic [DATA_W-1:0] w_wd_nxt;

    logic [1:0]        w_arb_valid;
    logic [1:0]        w_grant;
    logic              w_xfer;
    logic              w_prio_nxt;
    wr_req_t           w_req0;
    wr_req_t           w_req1;
    wr_req_t           w_sel;

    // Requests are only visible to the arbiter in RUN, and a clear_req in
    // the same cycle wins over any pending write.
    assign w_arb_valid = (r_state == ST_RUN && !clear_req)
                         ? {req1_valid, req0_valid} : 2'b00;

    rr_arb2 u_arb (
        .i_valid    (w_arb_valid),
        .i_prio     (r_prio),
        .i_transfer (w_xfer),
        .o_grant    (w_grant),
        .o_prio_nxt (w_prio_nxt)
    );

    // A grant is only given to a valid requester, so grant == transfer.
    assign w_xfer     = |w_grant;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign w_req0 = {req0_addr, req0_data};
    assign w_req1 = {req1_addr, req1_data};
    assign w_sel  = w_grant[1] ? w_req1 : w_req0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= CLR_FIRST;
            r_prio    <= 1'b0;
            r_we      <= 1'b0;
            r_wa      <= '0;
            r_wd      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_nxt;
            r_prio    <= w_prio_nxt;
            r_we      <= w_we_nxt;
            r_wa      <= w_wa_nxt;
            r_wd      <= w_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = r_clr_cnt;
        w_we_nxt    = 1'b0;
        w_wa_nxt    = r_wa;
        w_wd_nxt    = r_wd;
        case (r_state)
            ST_CLEAR: begin
                w_we_nxt = 1'b1;
                w_wa_nxt = r_clr_cnt;
                w_wd_nxt = '0;
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_clr_nxt   = CLR_FIRST;
                end else begin
                    w_clr_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_clr_nxt   = CLR_FIRST;
                end else if (w_xfer) begin
                    // Register 0 is hardwired: accept the write, drop the enable.
                    w_wa_nxt = w_sel.addr;
                    w_wd_nxt = w_sel.data;
                    w_we_nxt = (w_sel.addr != '0);
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_clr_nxt   = CLR_FIRST;
            end
        endcase
    end

    assign clear_busy = (r_state == ST_CLEAR);
    assign rf_we3     = r_we;
    assign rf_wa3     = r_wa;
    assign rf_wd3     = r_wd;

    // The write on rf_* commits at the next edge; forward it so readers in
    // this cycle already see the new value.
    assign rd1 = (r_we && ra1 == r_wa && ra1 != '0) ? r_wd : rf_rd1;
    assign rd2 = (r_we && ra2 == r_wa && ra2 != '0) ? r_wd : rf_rd2;

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        clear_busy;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_we3;
    logic [4:0]  rf_wa3;
    logic [31:0] rf_wd3;
    logic [4:0]  ra1, ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rd1, rd2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Register file model: commits the write port at the edge, reg 0 reads 0.
    logic [31:0] mem [0:31];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE0000 | i;
    end

    always @(posedge clock) begin
        if (rf_we3 && rf_wa3 != 5'd0) mem[rf_wa3] <= rf_wd3;
    end

    assign rf_rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
    assign rf_rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

    always #5 clock = ~clock;

    regfile_wr_sched dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_we3     (rf_we3),
        .rf_wa3     (rf_wa3),
        .rf_wd3     (rf_wd3),
        .ra1        (ra1),
        .ra2        (ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .rd1        (rd1),
        .rd2        (rd2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Walks the 31 zero-writes that follow reset release or CLEAR entry.
    // first_wa lets the caller skip writes it has already checked.
    task automatic expect_clear_run(input int first_wa, input string tag);
        for (int i = first_wa; i <= 31; i++) begin
            tick();
            n_cmp++;
            if (rf_we3 !== 1'b1 || rf_wa3 !== 5'(i) || rf_wd3 !== 32'd0) begin
                n_fail++;
                $display("FAIL %s_write[%0d]: got we=%b wa=%0d wd=%h, need we=1 wa=%0d wd=0",
                         tag, i, rf_we3, rf_wa3, rf_wd3, i);
            end
            n_cmp++;
            if (clear_busy !== (i < 31)) begin
                n_fail++;
                $display("FAIL %s_busy[%0d]: got %b need %b", tag, i, clear_busy, (i < 31));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_req = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        ra1 = '0; ra2 = '0;
        tick();
        tick();
        n_cmp++;
        if (rf_we3 !== 1'b0 || rf_wa3 !== 5'd0 || rf_wd3 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wport: got we=%b wa=%0d wd=%h need 0/0/0", rf_we3, rf_wa3, rf_wd3);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (clear_busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b rdy0=%b rdy1=%b need 1/0/0",
                     clear_busy, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        expect_clear_run(1, "clr");
        // Last zero-write commits here; then every register must read 0.
        tick();
        n_cmp++;
        if (rf_we3 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_we: got %b need 0", rf_we3);
        end
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1;
            n_cmp++;
            if (rd1 !== 32'd0) begin
                n_fail++;
                $display("FAIL cleared_rd1[%0d]: got %h need 0", a, rd1);
            end
        end
        ra1 = '0;
    endtask

    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hAAAAAAAA;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h55555555;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got rdy0=%b rdy1=%b need %b/%b",
                         k, req0_ready, req1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            tick();
            if (k == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            n_cmp++;
            if (rf_we3 !== 1'b1 || rf_wa3 !== ((k % 2 == 0) ? 5'd1 : 5'd2) ||
                rf_wd3 !== ((k % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555)) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: got we=%b wa=%0d wd=%h", k, rf_we3, rf_wa3, rf_wd3);
            end
        end
    endtask

    task automatic test_req0_only();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hFFFFFFFF;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req0_grant: got rdy0=%b rdy1=%b need 1/0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        ra1 = 5'd5; ra2 = 5'd6;
        #1;
        n_cmp++;
        if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd5 || rf_wd3 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL req0_write: got we=%b wa=%0d wd=%h need 1/5/ffffffff",
                     rf_we3, rf_wa3, rf_wd3);
        end
        n_cmp++;
        if (rd1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL bypass_rd1: got %h need ffffffff", rd1);
        end
        n_cmp++;
        if (rd2 !== 32'd0) begin
            n_fail++;
            $display("FAIL nobypass_rd2: got %h need 0", rd2);
        end
        tick();
        n_cmp++;
        if (rf_we3 !== 1'b0 || rf_wa3 !== 5'd5 || rd1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL req0_commit: got we=%b wa=%0d rd1=%h need 0/5/ffffffff",
                     rf_we3, rf_wa3, rd1);
        end
        ra1 = '0; ra2 = '0;
    endtask

    task automatic test_addr0();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h12345678;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL addr0_grant: got rdy1=%b rdy0=%b need 1/0", req1_ready, req0_ready);
        end
        tick();
        req1_valid = 1'b0;
        ra2 = 5'd0;
        #1;
        n_cmp++;
        if (rf_we3 !== 1'b0 || rf_wa3 !== 5'd0 || rf_wd3 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL addr0_write: got we=%b wa=%0d wd=%h need 0/0/12345678",
                     rf_we3, rf_wa3, rf_wd3);
        end
        n_cmp++;
        if (rd2 !== 32'd0) begin
            n_fail++;
            $display("FAIL addr0_rd2: got %h need 0", rd2);
        end
        tick();
        n_cmp++;
        if (rf_we3 !== 1'b0 || rf_wa3 !== 5'd0 || rf_wd3 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL idle_hold: got we=%b wa=%0d wd=%h need 0/0/12345678",
                     rf_we3, rf_wa3, rf_wd3);
        end
    endtask

    task automatic test_clear_req();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h00001234;
        clear_req = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b0 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clrreq_block: got rdy0=%b busy=%b need 0/0", req0_ready, clear_busy);
        end
        tick();
        clear_req = 1'b0;
        #1;
        n_cmp++;
        if (clear_busy !== 1'b1 || rf_we3 !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clrreq_enter: got busy=%b we=%b rdy0=%b need 1/0/0",
                     clear_busy, rf_we3, req0_ready);
        end
        expect_clear_run(1, "reclr");
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clrreq_resume: got rdy0=%b need 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd7 || rf_wd3 !== 32'h00001234) begin
            n_fail++;
            $display("FAIL clrreq_write: got we=%b wa=%0d wd=%h need 1/7/00001234",
                     rf_we3, rf_wa3, rf_wd3);
        end
    endtask

    task automatic test_reset_mid_clear();
        // Priority is now 1 (req0 was served last); reset must return it to 0.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        n_cmp++;
        if (rf_wa3 !== 5'd9 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclr_pos: got wa=%0d busy=%b need 9/1", rf_wa3, clear_busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rf_we3 !== 1'b0 || rf_wa3 !== 5'd0 || rf_wd3 !== 32'd0 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclr_reset: got we=%b wa=%0d wd=%h busy=%b need 0/0/0/1",
                     rf_we3, rf_wa3, rf_wd3, clear_busy);
        end
        tick();
        reset = 1'b0;
        expect_clear_run(1, "rstclr");
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000000A;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000000B;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_reset: got rdy0=%b rdy1=%b need 1/0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_req0_only();
        test_addr0();
        test_clear_req();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Write-port scheduler for the 3-port register file (2 read ports, 1 write port: we3/wa3/wd3).
- Shares the single write port between two writeback requesters with round-robin arbitration.
- Sequences a zero-clear of registers 1..NREG-1 after reset or on request.
- Provides same-cycle read bypass so readers see a write that is in flight to the register file.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers. Must equal 2**ADDR_W.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  pulse: start a clear sequence (honoured only in RUN).
- clear_busy  out  1  high while in CLEAR.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1.
- rf_we3  out  1  register-file write enable (registered).
- rf_wa3  out  ADDR_W  register-file write address (registered).
- rf_wd3  out  DATA_W  register-file write data (registered).
- ra1, ra2  in  ADDR_W  read addresses (also driven to the register file).
- rf_rd1, rf_rd2  in  DATA_W  raw read data from the register file.
- rd1, rd2  out  DATA_W  bypassed read data.

Behaviour:
- Reset (async, while high): state=CLEAR, clr_cnt=1, prio=0, rf_we3=0, rf_wa3=0, rf_wd3=0, clear_busy=1, both readies 0.
- States: CLEAR, RUN.
- CLEAR:
  - Each edge registers rf_we3=1, rf_wa3=clr_cnt, rf_wd3=0, then clr_cnt++.
  - Once the edge that issued NREG-1 has occurred: state becomes RUN and clr_cnt returns to 1.
  - The issue phase lasts exactly NREG-1 (31) edges after reset falls. The last zero-write is presented on rf_* during the first RUN cycle.
  - req0_ready=req1_ready=0 throughout; clear_req is ignored.
- RUN, grant (combinational, same cycle):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester indicated by prio gets ready=1.
  - Neither valid: both readies 0.
- RUN, transfer (valid&&ready at an edge):
  - Register rf_wa3=addr and rf_wd3=data.
  - rf_we3=1 if addr!=0. addr==0 is accepted and discarded: rf_we3=0, rf_wa3/rf_wd3 still registered.
  - prio flips to the non-granted requester after every transfer. No transfer leaves prio unchanged.
  - No transfer: rf_we3=0 next cycle; rf_wa3/rf_wd3 hold.
- clear_req in RUN:
  - Takes priority over any request: both readies 0 that cycle.
  - Next edge enters CLEAR with clr_cnt=1. It issues no write on that edge (rf_we3=0).
- Latency: an accepted write appears on rf_* 1 cycle after acceptance. The register file commits it at the following edge.
- Bypass (combinational): rdN = (rf_we3 && raN==rf_wa3 && raN!=0) ? rf_wd3 : rf_rdN, for N=1,2. This also applies to clear writes.
- Reset mid-CLEAR or mid-RUN: the sequence restarts from clr_cnt=1, and prio returns to 0.
- Requesters must hold addr/data stable while valid && !ready. The block does not buffer requests.
- clr_cnt width: ADDR_W bits; no wrap is reachable.

Decomposition:
- Package regfile_pkg: DATA_W, ADDR_W, NREG constants; state enum typedef {CLEAR, RUN}; typedef for a write request struct {addr, data}.
- One sub-module: rr_arb2, the 2-way round-robin arbiter (valid[1:0], prio, transfer -> grant[1:0], next prio).
- Bypass and clear sequencer stay in the top level.

Test Plan:
- Reset release, no requests -> rf_we3=1 for 31 consecutive cycles with rf_wa3=1..31 and rf_wd3=0. clear_busy falls in the cycle the last write (addr 31) is presented. The register file then reads 0 at all addresses.
- RUN, req0 only: addr=5, data=FFFFFFFF -> req0_ready=1 same cycle. Next cycle rf_we3=1, rf_wa3=5, rf_wd3=FFFFFFFF. With ra1=5 in that cycle, rd1=FFFFFFFF via bypass.
- Both valid, 4 cycles, held: req0 addr=1/AAAAAAAA, req1 addr=2/55555555 -> grants alternate req0, req1, req0, req1 starting with req0 (prio=0 after reset). rf_wa3 sequence is 1, 2, 1, 2.
- req1 writes addr=0, data=12345678 -> req1_ready=1, rf_we3=0 next cycle. With ra2=0, rd2=rf_rd2 (0), not bypassed.
- clear_req with req0_valid=1 in the same cycle -> req0_ready=0, CLEAR entered, clear_busy=1, 31 zero-writes follow. req0 is accepted on the first RUN cycle.
- Assert reset at clr_cnt=10 during CLEAR -> all outputs reset immediately. After release the clear restarts at rf_wa3=1.
